hpdcache_rrarb_lock: RTL and testbench
======================================

// Module: hpdcache_rrarb_lock
// PURPOSE
// - N-way arbiter with run-time selectable fixed-priority or round-robin policy.
// - Grant lock: holds a grant while the consumer stalls, and across multi-beat bursts until last_i.
// - Sits in front of shared HPDcache resources (miss handler, memory req port, RTAB) fed by several requesters.
// PARAMETERS
// - N          4   number of requesters (>=1)
// - MAX_WAIT   8   lost arbitrations before a requester becomes urgent (1..255); starvation guard only
// - IDX_W      $clog2(N)>0 ? $clog2(N) : 1   width of gnt_idx_o (localparam)
// PORTS
// - clk_i      in   1      clock, all state on rising edge
// - rst_i      in   1      synchronous reset, active-high
// - rr_mode_i  in   1      0: fixed priority (lowest index wins); 1: round-robin; sampled only in ARB
// - req_i      in   N      request vector; a granted requester keeps req high until its last beat is accepted
// - last_i     in   1      qualifies the accepted beat as the final beat of the granted transfer
// - ready_i    in   1      consumer accepts the beat; handshake = valid_o & ready_i
// - gnt_o      out  N      one-hot-or-zero grant vector
// - gnt_idx_o  out  IDX_W  binary index of the granted requester; 0 when valid_o=0
// - valid_o    out  1      |gnt_o
// BEHAVIOUR
// - Reset: while rst_i=1, gnt_o=0, gnt_idx_o=0, valid_o=0; state<=ARB, gnt_q<=0, rr_ptr<=0, wait counters<=0.
// - FSM states: ARB (combinational grant), HOLD (registered grant gnt_q).
// - ARB: gnt_o = arbitrate(req_i); zero-latency, valid in the same cycle as req_i.
//   - Fixed: lowest set index of req_i.
//   - RR: first set index at or after rr_ptr, wrapping N-1 -> 0.
//   - req_i=0: gnt_o=0, remain in ARB.
// - ARB->HOLD: valid_o & (~ready_i | (ready_i & ~last_i)); gnt_q <= gnt_o.
// - ARB->ARB: no request, or handshake with last_i=1 (single-beat transfer).
// - HOLD: gnt_o=gnt_q regardless of req_i, rr_mode_i and the urgency state.
//   - HOLD->ARB on handshake with last_i=1; a new grant is combinational in the next cycle.
//   - Handshake with last_i=0 stays in HOLD (burst).
// - rr_ptr update: only on a handshake with last_i=1, rr_ptr <= (granted idx + 1) mod N.
//   - rr_ptr is maintained in fixed mode as well, so switching mode mid-run is glitch-free.
// - Back-to-back: a requester may be re-granted the cycle after its last beat.
//   - In RR mode it wins again only if no other requester is pending.
// - Protocol violation: req_i[gnt] dropping while in HOLD is flagged by an assertion.
//   - The grant is still held until last_i.
// - N=1: the grant follows req_i[0]; rr_ptr stays 0.
// - Assertions (sim only): $onehot0(gnt_o); gnt_o stable while valid_o & ~ready_i; gnt_idx_o matches gnt_o.
// CONFIGURATION
// - Macro HPDCACHE_ARB_STARVATION_EN.
// - Defined: per-requester saturating counter wait_q[i] (8 bits).
//   - Increments when the ARB decision completes with last_i=1 to another requester while req_i[i]=1.
//   - Cleared when requester i is granted in ARB.
//   - urgent[i] = wait_q[i] >= MAX_WAIT.
//   - If any urgent requester is pending, the lowest-index urgent requester wins, overriding both policies.
//   - Counters freeze while in HOLD.
// - Undefined: no counters or urgency logic are generated; MAX_WAIT is ignored; behaviour is pure fixed/RR.
// TESTING
// - Fixed, N=4, req=4'b1010, ready=1, last=1 -> gnt=4'b0010 idx=1 same cycle; next cycle req=4'b1000 -> gnt=4'b1000.
// - RR, req=4'b1111 held, ready=1, last=1 each cycle -> grants 0,1,2,3,0 in successive cycles.
// - Stall: req=4'b0100, ready=0 for 3 cycles, req=4'b0101 raised in cycle 2 -> gnt held 4'b0100 until ready=1.
//   - Then gnt=4'b0001 the next cycle.
// - Burst: req[1] granted, 4 beats with last=0,0,0,1 and req[0] high throughout -> gnt=4'b0010 for all 4 beats.
//   - req[0] is granted only after the last=1 handshake.
// - Reset mid-burst: rst_i=1 in HOLD -> gnt_o=0 that cycle.
//   - After release, RR restarts from index 0 (req=4'b1111 -> gnt=4'b0001).
// - STARVATION_EN, fixed, MAX_WAIT=2, req=4'b1100 continuously with req[0] re-pulsed each cycle.
//   - req[2] wins after 2 lost decisions, then its counter clears.

Source files
------------

// File: rtl/hpdcache_rrarb_lock.sv
// N-way arbiter with run-time fixed-priority / round-robin policy and a grant lock that holds
// across consumer stalls and multi-beat bursts. Starvation guard: define HPDCACHE_ARB_STARVATION_EN.
module hpdcache_rrarb_lock #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_WAIT = 8,
  localparam int unsigned IDX_W   = ($clog2(N) > 0) ? $clog2(N) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rr_mode_i,
  input  logic [N-1:0]     req_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             valid_o
);

  typedef enum logic {StArb, StHold} state_e;

  state_e           state_q;
  logic [N-1:0]     gnt_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] rr_ptr_d;
  logic [N-1:0]     fix_gnt;
  logic [N-1:0]     rr_gnt;
  logic [N-1:0]     arb_gnt;
  logic [N-1:0]     hi_mask;
  logic             hs_last;

  function automatic logic [N-1:0] lowest_set(input logic [N-1:0] v);
    logic [N-1:0] r;
    logic         found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (!found && v[i]) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Round-robin: lowest request at or above the pointer, else wrap to the lowest overall.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < int'(N); i++) begin
      hi_mask[i] = (i >= int'(rr_ptr_q));
    end
    fix_gnt = lowest_set(req_i);
    rr_gnt  = (|(req_i & hi_mask)) ? lowest_set(req_i & hi_mask) : fix_gnt;
  end

`ifdef HPDCACHE_ARB_STARVATION_EN
  logic [7:0]   wait_q [N];
  logic [N-1:0] urgent;

  always_comb begin
    urgent = '0;
    for (int i = 0; i < int'(N); i++) begin
      urgent[i] = (wait_q[i] >= 8'(MAX_WAIT));
    end
  end

  always_comb begin
    arb_gnt = rr_mode_i ? rr_gnt : fix_gnt;
    if (|(req_i & urgent)) arb_gnt = lowest_set(req_i & urgent);
  end

  // Counters only move on ARB decisions; a locked grant freezes them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(N); i++) wait_q[i] <= '0;
    end else if (state_q == StArb) begin
      for (int i = 0; i < int'(N); i++) begin
        if (gnt_o[i]) begin
          wait_q[i] <= '0;
        end else if (hs_last && req_i[i] && (wait_q[i] != 8'hff)) begin
          wait_q[i] <= wait_q[i] + 8'd1;
        end
      end
    end
  end
`else
  always_comb begin
    arb_gnt = rr_mode_i ? rr_gnt : fix_gnt;
  end
`endif

  always_comb begin
    gnt_o = '0;
    if (!rst_i) gnt_o = (state_q == StHold) ? gnt_q : arb_gnt;
    valid_o   = |gnt_o;
    gnt_idx_o = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (gnt_o[i]) gnt_idx_o = IDX_W'(i);
    end
    hs_last  = valid_o & ready_i & last_i;
    rr_ptr_d = (int'(gnt_idx_o) == int'(N) - 1) ? '0 : gnt_idx_o + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StArb;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      if (hs_last) rr_ptr_q <= rr_ptr_d;
      unique case (state_q)
        StArb: begin
          if (valid_o && !(ready_i && last_i)) begin
            state_q <= StHold;
            gnt_q   <= gnt_o;
          end
        end
        StHold: begin
          if (hs_last) begin
            state_q <= StArb;
            gnt_q   <= '0;
          end
        end
        default: state_q <= StArb;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_cfg_max_wait: assert property (@(posedge clk_i) (MAX_WAIT >= 1) && (MAX_WAIT <= 255));
  a_onehot: assert property (@(posedge clk_i) $onehot0(gnt_o));
  a_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_o && !ready_i) |=> $stable(gnt_o));
  a_idx_valid: assert property (@(posedge clk_i) valid_o |-> (gnt_o == (N'(1) << gnt_idx_o)));
  a_idx_zero: assert property (@(posedge clk_i) !valid_o |-> (gnt_idx_o == '0));
  a_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == StHold) |-> (|(req_i & gnt_q)));
`endif

endmodule

// File: tb/tb_hpdcache_rrarb_lock.sv
// Self-checking bench for hpdcache_rrarb_lock: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_hpdcache_rrarb_lock;
  localparam int N        = 4;
  localparam int MAX_WAIT = 2;
`ifdef HPDCACHE_ARB_STARVATION_EN
  localparam bit STARV = 1'b1;
`else
  localparam bit STARV = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         rr_mode;
  logic [N-1:0] req;
  logic         last;
  logic         ready;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_idx;
  logic         valid;

  int checks   = 0;
  int failures = 0;

  // Reference model: lock owner, round-robin pointer, per-requester lost-decision counts.
  bit m_locked;
  int m_lidx;
  int m_ptr;
  int m_wait [N];

  always #5 clk = ~clk;

  hpdcache_rrarb_lock #(
    .N        (N),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .rr_mode_i (rr_mode),
    .req_i     (req),
    .last_i    (last),
    .ready_i   (ready),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .valid_o   (valid)
  );

  function automatic bit bit_of(input logic [N-1:0] v, input int j);
    logic [N-1:0] t;
    t = v >> j;
    return t[0];
  endfunction

  function automatic logic [1:0] enc(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (bit_of(v, i)) return 2'(i);
    return 2'd0;
  endfunction

  function automatic logic [N-1:0] vec_of(input int e);
    if (e < 0) return '0;
    return N'(1) << e;
  endfunction

  function automatic int model_idx();
    if (rst) return -1;
    if (m_locked) return m_lidx;
    if (req == '0) return -1;
    if (STARV) begin
      for (int i = 0; i < N; i++) if (bit_of(req, i) && m_wait[i] >= MAX_WAIT) return i;
    end
    if (rr_mode) begin
      for (int k = 0; k < N; k++) if (bit_of(req, (m_ptr + k) % N)) return (m_ptr + k) % N;
    end else begin
      for (int i = 0; i < N; i++) if (bit_of(req, i)) return i;
    end
    return -1;
  endfunction

  task automatic apply(input logic r, input logic m, input logic [N-1:0] q, input logic l,
                       input logic y);
    @(negedge clk);
    rst = r; rr_mode = m; req = q; last = l; ready = y;
    #1;
  endtask

  // Advance the model across the rising edge with the inputs currently applied.
  task automatic commit();
    int e;
    bit hl;
    e = model_idx();
    @(posedge clk);
    if (rst) begin
      m_locked = 1'b0;
      m_ptr    = 0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
    end else if (e >= 0) begin
      hl = ready && last;
      if (!m_locked) begin
        if (hl) begin
          for (int i = 0; i < N; i++)
            if (i != e && bit_of(req, i) && m_wait[i] < 255) m_wait[i]++;
        end
        m_wait[e] = 0;
        if (!hl) begin
          m_locked = 1'b1;
          m_lidx   = e;
        end
      end else if (hl) begin
        m_locked = 1'b0;
      end
      if (hl) m_ptr = (e + 1) % N;
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      apply(1'b1, 1'b0, 4'b1111, 1'b1, 1'b1);
      checks++;
      if (gnt !== 4'b0000 || gnt_idx !== 2'd0 || valid !== 1'b0) begin
        failures++;
        $display("FAIL reset[%0d] gnt=%b idx=%0d valid=%b required gnt=0000 idx=0 valid=0",
                 k, gnt, gnt_idx, valid);
      end
      commit();
    end
  endtask

  task automatic test_fixed();
    logic [N-1:0] rq [2] = '{4'b1010, 4'b1000};
    logic [N-1:0] eg [2] = '{4'b0010, 4'b1000};
    for (int k = 0; k < 2; k++) begin
      apply(1'b0, 1'b0, rq[k], 1'b1, 1'b1);
      checks++;
      if (gnt !== eg[k] || gnt_idx !== enc(eg[k]) || valid !== 1'b1) begin
        failures++;
        $display("FAIL fixed[%0d] gnt=%b idx=%0d valid=%b required gnt=%b idx=%0d valid=1",
                 k, gnt, gnt_idx, valid, eg[k], enc(eg[k]));
      end
      commit();
    end
  endtask

  task automatic test_rr();
    logic [N-1:0] eg [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
    commit();
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, 1'b1, 4'b1111, 1'b1, 1'b1);
      checks++;
      if (gnt !== eg[k] || gnt_idx !== enc(eg[k]) || valid !== 1'b1) begin
        failures++;
        $display("FAIL rr[%0d] gnt=%b idx=%0d valid=%b required gnt=%b idx=%0d valid=1",
                 k, gnt, gnt_idx, valid, eg[k], enc(eg[k]));
      end
      commit();
    end
  endtask

  task automatic test_stall();
    logic [N-1:0] rq [5] = '{4'b0100, 4'b0101, 4'b0101, 4'b0101, 4'b0101};
    logic         rd [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [N-1:0] eg [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
    apply(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    commit();
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, 1'b0, rq[k], 1'b1, rd[k]);
      checks++;
      if (gnt !== eg[k] || gnt_idx !== enc(eg[k]) || valid !== 1'b1) begin
        failures++;
        $display("FAIL stall[%0d] gnt=%b idx=%0d valid=%b required gnt=%b idx=%0d valid=1",
                 k, gnt, gnt_idx, valid, eg[k], enc(eg[k]));
      end
      commit();
    end
  endtask

  task automatic test_burst();
    logic [N-1:0] rq [6] = '{4'b0001, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011};
    logic         ls [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [N-1:0] eg [6] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    apply(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
    commit();
    for (int k = 0; k < 6; k++) begin
      apply(1'b0, 1'b1, rq[k], ls[k], 1'b1);
      checks++;
      if (gnt !== eg[k] || gnt_idx !== enc(eg[k]) || valid !== 1'b1) begin
        failures++;
        $display("FAIL burst[%0d] gnt=%b idx=%0d valid=%b required gnt=%b idx=%0d valid=1",
                 k, gnt, gnt_idx, valid, eg[k], enc(eg[k]));
      end
      commit();
    end
  endtask

  task automatic test_reset_mid_burst();
    logic         rs [3] = '{1'b0, 1'b1, 1'b0};
    logic [N-1:0] rq [3] = '{4'b0100, 4'b0100, 4'b1111};
    logic         ls [3] = '{1'b0, 1'b0, 1'b1};
    logic [N-1:0] eg [3] = '{4'b0100, 4'b0000, 4'b0001};
    for (int k = 0; k < 3; k++) begin
      apply(rs[k], 1'b1, rq[k], ls[k], 1'b1);
      checks++;
      if (gnt !== eg[k] || gnt_idx !== enc(eg[k]) || valid !== (|eg[k])) begin
        failures++;
        $display("FAIL rst_burst[%0d] gnt=%b idx=%0d valid=%b required gnt=%b idx=%0d valid=%b",
                 k, gnt, gnt_idx, valid, eg[k], enc(eg[k]), |eg[k]);
      end
      commit();
    end
  endtask

  task automatic test_back_to_back();
    logic         md [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [N-1:0] rq [4] = '{4'b0010, 4'b0010, 4'b0110, 4'b0110};
    logic [N-1:0] eg [4] = '{4'b0010, 4'b0010, 4'b0100, 4'b0010};
    apply(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
    commit();
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, md[k], rq[k], 1'b1, 1'b1);
      checks++;
      if (gnt !== eg[k] || gnt_idx !== enc(eg[k]) || valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b[%0d] gnt=%b idx=%0d valid=%b required gnt=%b idx=%0d valid=1",
                 k, gnt, gnt_idx, valid, eg[k], enc(eg[k]));
      end
      commit();
    end
  endtask

`ifdef HPDCACHE_ARB_STARVATION_EN
  task automatic test_starvation();
    logic [N-1:0] eg [5] = '{4'b0001, 4'b0001, 4'b0100, 4'b1000, 4'b0001};
    apply(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    commit();
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, 1'b0, 4'b1101, 1'b1, 1'b1);
      checks++;
      if (gnt !== eg[k] || gnt_idx !== enc(eg[k]) || valid !== 1'b1) begin
        failures++;
        $display("FAIL starve[%0d] gnt=%b idx=%0d valid=%b required gnt=%b idx=%0d valid=1",
                 k, gnt, gnt_idx, valid, eg[k], enc(eg[k]));
      end
      commit();
    end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] q;
    logic [N-1:0] eg;
    int           e;
    for (int k = 0; k < 2000; k++) begin
      q = N'($urandom);
      if (m_locked) q = q | vec_of(m_lidx);
      apply(($urandom_range(0, 63) == 0), 1'($urandom), q, 1'($urandom),
            ($urandom_range(0, 3) != 0));
      e  = model_idx();
      eg = vec_of(e);
      checks++;
      if (gnt !== eg || gnt_idx !== enc(eg) || valid !== (e >= 0)) begin
        failures++;
        $display("FAIL random[%0d] gnt=%b idx=%0d valid=%b required gnt=%b idx=%0d valid=%b",
                 k, gnt, gnt_idx, valid, eg, enc(eg), (e >= 0));
      end
      commit();
    end
  endtask

  initial begin
    rst = 1'b1; rr_mode = 1'b0; req = '0; last = 1'b0; ready = 1'b0;
    m_locked = 1'b0; m_lidx = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
    test_reset();
    test_fixed();
    test_rr();
    test_stall();
    test_burst();
    test_reset_mid_burst();
    test_back_to_back();
`ifdef HPDCACHE_ARB_STARVATION_EN
    test_starvation();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
